// File: rtl/modn_counter_pkg.sv
// modn_counter_pkg: shared FSM state encodings and direction constants for modn_counter
package modn_counter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/modn_counter_if.sv
// modn_counter_if: control/status bundle of modn_counter; load/d exist only with MODN_CNT_LOAD_EN
interface modn_counter_if #(parameter int WIDTH = 3);
    logic             start;
    logic             stop;
    logic             en;
    logic             dir;
    logic             oneshot;
`ifdef MODN_CNT_LOAD_EN
    logic             load;
    logic [WIDTH-1:0] d;
`endif
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
    logic             done;
`ifdef MODN_CNT_LOAD_EN
    modport master (output start, stop, en, dir, oneshot, load, d, input q, tc, busy, done);
    modport slave  (input start, stop, en, dir, oneshot, load, d, output q, tc, busy, done);
`else
    modport master (output start, stop, en, dir, oneshot, input q, tc, busy, done);
    modport slave  (input start, stop, en, dir, oneshot, output q, tc, busy, done);
`endif
endinterface

// File: rtl/modn_step.sv
// modn_step: combinational modulo-MODULUS increment/decrement with wrap flag
module modn_step
    import modn_counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 5
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    always_comb begin
        wrap = (dir == DIR_UP) ? (q == MAXV) : (q == '0);
        nxt  = (dir == DIR_UP) ? (wrap ? '0 : q + 1'b1) : (wrap ? MAXV : q - 1'b1);
    end
endmodule

// File: rtl/modn_counter.sv
// modn_counter: modulo-N up/down counter with IDLE/RUN/DONE run control and terminal-count pulse.
// Define MODN_CNT_LOAD_EN to add the synchronous load port (load/d, clamped to MODULUS-1).
module modn_counter
    import modn_counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    modn_counter_if.slave   bus
);
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("modn_counter: MODULUS must lie in 2..2**WIDTH");
    end
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    state_t           state;
    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic [WIDTH-1:0] nxt;
    logic             wrap;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             cnt;
`ifdef MODN_CNT_LOAD_EN
    assign ld     = bus.load;
    assign ld_val = (bus.d > MAXV) ? MAXV : bus.d;
`else
    assign ld     = 1'b0;
    assign ld_val = '0;
`endif
    // a load on the same edge overrides counting, so it can never produce a wrap or TC
    assign cnt = (state == ST_RUN) && bus.en && !ld;
    modn_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step (
        .q    (q_r),
        .dir  (bus.dir),
        .nxt  (nxt),
        .wrap (wrap)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            q_r   <= '0;
            tc_r  <= 1'b0;
        end else begin
            tc_r <= 1'b0;
            if (bus.stop)
                state <= ST_IDLE;
            else if (bus.start && state != ST_RUN)
                state <= ST_RUN;
            else if (cnt) begin
                q_r  <= nxt;
                tc_r <= wrap;
                if (wrap && bus.oneshot)
                    state <= ST_DONE;
            end
            if (ld)
                q_r <= ld_val;
        end
    end
    assign bus.q    = q_r;
    assign bus.tc   = tc_r;
    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_DONE);
endmodule

// File: tb/tb_modn_counter.sv
// tb_modn_counter: directed vector table plus hand sequences for reset, load and a 4-bit mod-16 wrap
module tb_modn_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    always #5 clk = ~clk;
    modn_counter_if #(.WIDTH(3)) bus ();
    modn_counter_if #(.WIDTH(4)) bus16 ();
    modn_counter #(.WIDTH(3), .MODULUS(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    modn_counter #(.WIDTH(4), .MODULUS(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    typedef struct {
        logic start, stop, en, dir, oneshot;
        int   q;
        logic tc, busy, done;
    } vec_t;
    vec_t vecs[$];
    task automatic add(input logic s, p, e, dr, o, input int q, input logic t, b, d);
        vec_t v;
        v.start = s; v.stop = p; v.en = e; v.dir = dr; v.oneshot = o;
        v.q = q; v.tc = t; v.busy = b; v.done = d;
        vecs.push_back(v);
    endtask
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    task automatic apply(input int i);
        bus.start = vecs[i].start; bus.stop = vecs[i].stop; bus.en = vecs[i].en;
        bus.dir = vecs[i].dir; bus.oneshot = vecs[i].oneshot;
        @(posedge clk); #1;
        chk($sformatf("v%0d_q", i), int'(bus.q), vecs[i].q);
        chk($sformatf("v%0d_tc", i), int'(bus.tc), int'(vecs[i].tc));
        chk($sformatf("v%0d_busy", i), int'(bus.busy), int'(vecs[i].busy));
        chk($sformatf("v%0d_done", i), int'(bus.done), int'(vecs[i].done));
    endtask
    int split;
    initial begin
        {bus.start, bus.stop, bus.en, bus.dir, bus.oneshot} = '0;
        {bus16.start, bus16.stop, bus16.en, bus16.dir, bus16.oneshot} = '0;
`ifdef MODN_CNT_LOAD_EN
        bus.load = 1'b0; bus.d = '0; bus16.load = 1'b0; bus16.d = '0;
`endif
        // start, then up 11 counts with wraps after the 4->0 edges
        add(1,0,1,1,0, 0,0,1,0);
        for (int k = 1; k <= 11; k++) add(0,0,1,1,0, k % 5, (k % 5) == 0, 1, 0);
        // down from 1, then EN gating
        add(0,0,1,0,0, 0,0,1,0);
        add(0,0,1,0,0, 4,1,1,0);
        add(0,0,0,0,0, 4,0,1,0);
        add(0,0,1,0,0, 3,0,1,0);
        // stop during run, then start+stop in idle
        add(0,1,1,1,0, 3,0,0,0);
        add(1,1,1,1,0, 3,0,0,0);
        add(1,0,0,1,0, 3,0,1,0);
        add(0,0,1,1,0, 4,0,1,0);
        add(0,0,1,1,0, 0,1,1,0);
        split = vecs.size();
        // one-shot from 0 after reset
        add(1,0,0,1,1, 0,0,1,0);
        for (int k = 1; k <= 4; k++) add(0,0,1,1,1, k,0,1,0);
        add(0,0,1,1,1, 0,1,0,1);
        add(0,0,1,1,1, 0,0,0,1);
        add(0,0,1,0,1, 0,0,0,1);
        add(1,0,1,1,1, 0,0,1,0);
        add(0,0,1,1,1, 1,0,1,0);
        add(0,1,1,1,1, 1,0,0,0);
        #2;
        chk("rst_q", int'(bus.q), 0);
        chk("rst_tc", int'(bus.tc), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < split; i++) apply(i);
        // asynchronous reset between edges while TC is high
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q", int'(bus.q), 0);
        chk("arst_tc", int'(bus.tc), 0);
        chk("arst_busy", int'(bus.busy), 0);
        #2 rst_n = 1'b1;
        for (int i = split; i < vecs.size(); i++) apply(i);
`ifdef MODN_CNT_LOAD_EN
        {bus.start, bus.stop, bus.en, bus.dir, bus.oneshot} = 5'b00010;
        bus.load = 1'b1; bus.d = 3'd3;
        @(posedge clk); #1;
        chk("ld3_q", int'(bus.q), 3);
        chk("ld3_busy", int'(bus.busy), 0);
        bus.d = 3'd7;
        @(posedge clk); #1;
        chk("ld7_clamp_q", int'(bus.q), 4);
        bus.load = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        chk("ld_start_busy", int'(bus.busy), 1);
        bus.start = 1'b0; bus.en = 1'b1; bus.load = 1'b1; bus.d = 3'd2;
        @(posedge clk); #1;
        chk("ld_run_q", int'(bus.q), 2);
        chk("ld_run_tc", int'(bus.tc), 0);
        bus.load = 1'b0;
        @(posedge clk); #1;
        chk("ld_cnt_q", int'(bus.q), 3);
        bus.stop = 1'b1; bus.load = 1'b1; bus.d = 3'd0;
        @(posedge clk); #1;
        chk("ld_stop_q", int'(bus.q), 0);
        chk("ld_stop_busy", int'(bus.busy), 0);
        bus.stop = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
`endif
        // 4-bit mod-16 full wrap
        bus16.dir = 1'b1; bus16.start = 1'b1;
        @(posedge clk); #1;
        chk("m16_start_q", int'(bus16.q), 0);
        bus16.start = 1'b0; bus16.en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            chk($sformatf("m16_q%0d", k), int'(bus16.q), k);
        end
        chk("m16_tc_pre", int'(bus16.tc), 0);
        @(posedge clk); #1;
        chk("m16_wrap_q", int'(bus16.q), 0);
        chk("m16_wrap_tc", int'(bus16.tc), 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
